sparam_sweep_ctrl: RTL and testbench

//  Sequences a two-port S-parameter frequency sweep of the LPF/balun test fixture.
//  Per point: 1) applies DC bias (the 1 V supply into the transformer centre taps);
//  2) steps the frequency word; 3) excites port 1 then port 2 through a one-hot port switch;
//  4) handshakes with the measurement engine.

---
 rtl/sparam_sweep_pkg.sv | 29 ++
 rtl/sparam_sweep_ctrl_if.sv | 31 +++
 rtl/sparam_sweep_ctrl_timer.sv | 25 ++
 rtl/sparam_sweep_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sparam_sweep_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sparam_sweep_pkg.sv
// Shared types and constants for the two-port S-parameter sweep controller.
package sparam_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    FREQ,
    SETTLE,
    MEAS,
    NEXT,
    DONE
  } state_t;

  // One-hot excitation port select.
  localparam logic [1:0] PORT_NONE = 2'b00;
  localparam logic [1:0] PORT_P1   = 2'b01;
  localparam logic [1:0] PORT_P2   = 2'b10;

  // Width of the shared down-counter: must hold the largest (count - 1).
  function automatic int timer_width(input int bias_cyc, input int settle_cyc,
                                     input int tmo_cyc);
    int m;
    m = bias_cyc;
    if (settle_cyc > m) m = settle_cyc;
    if (tmo_cyc > m) m = tmo_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sparam_sweep_ctrl_if.sv
// Host + measurement-datapath bundle of the sweep controller.
// slave: the controller itself; master: the host/engine side driving it.
interface sparam_sweep_if #(
  parameter int FREQ_W = 16,
  parameter int PTS_W  = 10
);
  logic              start;
  logic              abort;
  logic [FREQ_W-1:0] f_start;
  logic [FREQ_W-1:0] f_step;
  logic [PTS_W-1:0]  n_points;
  logic              bias_en;
  logic [1:0]        port_sel;
  logic [FREQ_W-1:0] freq;
  logic [PTS_W-1:0]  point_idx;
  logic              meas_req;
  logic              meas_ack;
  logic              busy;
  logic              done;
  logic              err_tmo;

  modport master (
    output start, abort, f_start, f_step, n_points, meas_ack,
    input  bias_en, port_sel, freq, point_idx, meas_req, busy, done, err_tmo
  );

  modport slave (
    input  start, abort, f_start, f_step, n_points, meas_ack,
    output bias_en, port_sel, freq, point_idx, meas_req, busy, done, err_tmo
  );
endinterface

// File: rtl/sparam_sweep_ctrl_timer.sv
// Single down-counter shared by bias-settle, RF-settle and the ack timeout.
// Loading value N makes expired assert N cycles after the load edge.
module sweep_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) on every flop so all registers see pre-edge values.
    if (rst)                count <= '0;
    else if (load)          count <= value;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/sparam_sweep_ctrl.sv
// Sequences bias, frequency stepping, port 1/2 excitation and the measurement
// handshake for each point of a two-port S-parameter sweep.
module sparam_sweep_ctrl
  import sparam_sweep_pkg::*;
#(
  parameter int FREQ_W     = 16,
  parameter int PTS_W      = 10,
  parameter int BIAS_CYC   = 1024,
  parameter int SETTLE_CYC = 64,
  parameter int TMO_CYC    = 4096
) (
  input logic           clk,
  input logic           rst,
  sparam_sweep_if.slave bus
);

  localparam int TMR_W = timer_width(BIAS_CYC, SETTLE_CYC, TMO_CYC);
  // Each phase lasts exactly N cycles when the counter is loaded with N-1.
  localparam logic [TMR_W-1:0] BIAS_LD   = TMR_W'(BIAS_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LD    = TMR_W'(TMO_CYC - 1);

  state_t            state;
  logic              bias_en, meas_req, done, err_tmo;
  logic [1:0]        port_sel;
  logic [FREQ_W-1:0] freq, f_start_r, f_step_r;
  logic [PTS_W-1:0]  point_idx, n_points_r;

  logic              tmr_load, tmr_expired;
  logic [TMR_W-1:0]  tmr_value;
  logic              abort_hit;

  // DONE is already unwinding the sweep, so abort only matters before it.
  assign abort_hit = bus.abort && (state != IDLE) && (state != DONE);

  sweep_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  // Arm the shared timer on the same edge that enters a timed state.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals; no latch inferred.
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      IDLE:   if (bus.start && bus.n_points != '0) begin
                tmr_load  = 1'b1;
                tmr_value = BIAS_LD;
              end
      FREQ:   begin
                tmr_load  = 1'b1;
                tmr_value = SETTLE_LD;
              end
      SETTLE: if (tmr_expired) begin
                tmr_load  = 1'b1;
                tmr_value = TMO_LD;
              end
      MEAS:   if (bus.meas_ack && port_sel == PORT_P1) begin
                tmr_load  = 1'b1;
                tmr_value = SETTLE_LD;
              end
      default: ;
    endcase
  end

  // Sweep FSM with registered outputs, frequency and point-index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bias_en    <= 1'b0;
      port_sel   <= PORT_NONE;
      freq       <= '0;
      point_idx  <= '0;
      meas_req   <= 1'b0;
      done       <= 1'b0;
      err_tmo    <= 1'b0;
      f_start_r  <= '0;
      f_step_r   <= '0;
      n_points_r <= '0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        state    <= DONE;
        bias_en  <= 1'b0;
        port_sel <= PORT_NONE;
        meas_req <= 1'b0;
        done     <= 1'b1;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            f_start_r  <= bus.f_start;
            f_step_r   <= bus.f_step;
            n_points_r <= bus.n_points;
            point_idx  <= '0;
            err_tmo    <= 1'b0;
            if (bus.n_points == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= BIAS;
              bias_en <= 1'b1;
            end
          end
          BIAS: if (tmr_expired) state <= FREQ;
          FREQ: begin
            // Frequency word wraps modulo 2^FREQ_W by construction.
            freq     <= (point_idx == '0) ? f_start_r : freq + f_step_r;
            port_sel <= PORT_P1;
            state    <= SETTLE;
          end
          SETTLE: if (tmr_expired) begin
            meas_req <= 1'b1;
            state    <= MEAS;
          end
          MEAS: begin
            // An ack on the timeout cycle still counts: ack is tested first.
            if (bus.meas_ack) begin
              meas_req <= 1'b0;
              if (port_sel == PORT_P1) begin
                port_sel <= PORT_P2;
                state    <= SETTLE;
              end else begin
                port_sel <= PORT_NONE;
                state    <= NEXT;
              end
            end else if (tmr_expired) begin
              meas_req <= 1'b0;
              err_tmo  <= 1'b1;
              bias_en  <= 1'b0;
              port_sel <= PORT_NONE;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
          NEXT: if (point_idx == n_points_r - 1'b1) begin
            bias_en <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            point_idx <= point_idx + 1'b1;
            state     <= FREQ;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.bias_en   = bias_en;
  assign bus.port_sel  = port_sel;
  assign bus.freq      = freq;
  assign bus.point_idx = point_idx;
  assign bus.meas_req  = meas_req;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
  assign bus.err_tmo   = err_tmo;

endmodule

// File: tb/tb_sparam_sweep_ctrl.sv
// Scoreboard bench for sparam_sweep_ctrl: a sweep-level model pushes the
// expected measurement requests and end-of-sweep results; an engine process
// answers requests per a random plan; a monitor pops and compares.
module tb_sparam_sweep_ctrl;

  localparam int B = 8;
  localparam int S = 4;
  localparam int T = 16;

  typedef struct {
    logic [15:0] freq;
    logic [1:0]  port;
    int          idx;
    int          len;   // expected meas_req high cycles, -1 = do not check
    longint      cyc;   // expected rise cycle, -1 = do not check
  } req_t;

  typedef struct {
    logic   err;
    longint cyc;        // -1 = unchecked, -2 = one cycle after abort
  } done_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;

  req_t   exp_req[$];
  done_t  exp_done[$];
  int     plan[$];          // per request: ack delay in cycles, -1 = never ack
  int     abort_k = -1;     // request after whose ack abort is raised
  int     abort_j = 0;      // extra cycles into SETTLE before abort
  longint abort_cyc = -1;
  logic [15:0] model_freq = '0;
  int     model_idx = 0;

  sparam_sweep_if #(.FREQ_W(16), .PTS_W(10)) bus ();

  sparam_sweep_ctrl #(
    .FREQ_W(16), .PTS_W(10), .BIAS_CYC(B), .SETTLE_CYC(S), .TMO_CYC(T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bias_en"}, bus.bias_en, 0);
    check({tag, "_port_sel"}, bus.port_sel, 0);
    check({tag, "_freq"}, bus.freq, 0);
    check({tag, "_point_idx"}, bus.point_idx, 0);
    check({tag, "_meas_req"}, bus.meas_req, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err_tmo"}, bus.err_tmo, 0);
  endtask

  // Run one sweep from a negedge in IDLE; returns at the negedge after done.
  task automatic run_sweep(input logic [15:0] fs, input logic [15:0] st, input int n,
                           input int tmo_k, input int ab_k, input int ab_j,
                           input int force_d, input int same_k);
    int     last_k;
    logic   err_exp;
    longint c0;
    logic   got;
    int     bias_cnt;
    req_t   r;
    done_t  dn;
    plan.delete();
    for (int k = 0; k < 2 * n; k++) begin
      int d;
      d = (force_d >= 0) ? force_d : int'($urandom_range(0, 5));
      if (k == same_k) d = T - 1;
      if (k == tmo_k) d = -1;
      plan.push_back(d);
    end
    abort_k = ab_k;
    abort_j = ab_j;
    last_k  = 2 * n - 1;
    if (tmo_k >= 0) last_k = tmo_k;
    if (ab_k >= 0) last_k = ab_k;
    err_exp = (tmo_k >= 0);
    c0 = cyc;
    for (int k = 0; k <= last_k; k++) begin
      r.freq = 16'(fs + (k / 2) * st);
      r.port = (k % 2 == 0) ? 2'b01 : 2'b10;
      r.idx  = k / 2;
      r.len  = (plan[k] < 0) ? T : plan[k] + 1;
      r.cyc  = (k == 0) ? c0 + 2 + B + S : -1;
      exp_req.push_back(r);
    end
    if (n > 0) begin
      model_freq = 16'(fs + (last_k / 2) * st);
      model_idx  = last_k / 2;
    end
    dn.err = (ab_k >= 0) ? 1'b0 : err_exp;
    dn.cyc = (ab_k >= 0) ? -2 : ((n == 0) ? c0 + 1 : -1);
    exp_done.push_back(dn);

    bus.f_start  = fs;
    bus.f_step   = st;
    bus.n_points = 10'(n);
    bus.start    = 1'b1;
    got = 1'b0;
    bias_cnt = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      bus.start = (t == 2 && n > 0);   // a start while busy must be ignored
      if (t == 0 || t == 3) begin
        bus.f_start  = 16'($urandom);
        bus.f_step   = 16'($urandom);
        bus.n_points = 10'($urandom);
      end
      if (bus.bias_en) bias_cnt++;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    check("sweep_done_seen", got, 1);
    if (n == 0) check("bias_never_on", bias_cnt, 0);
    @(negedge clk);
    bus.start = 1'b0;
    check("idle_busy", bus.busy, 0);
    check("idle_bias_en", bus.bias_en, 0);
    check("idle_freq_hold", bus.freq, model_freq);
    check("idle_err_tmo", bus.err_tmo, err_exp);
    if (n > 0) check("idle_point_idx", bus.point_idx, model_idx);
    check("req_queue_drained", exp_req.size(), 0);
    check("done_queue_drained", exp_done.size(), 0);
  endtask

  // Measurement engine: acks each request after its planned delay, raises abort.
  initial begin
    longint ack_at, abort_at;
    int     req_k, d;
    logic   req_prev, busy_prev;
    ack_at = -1; abort_at = -1; req_k = 0; req_prev = 0; busy_prev = 0;
    bus.meas_ack = 1'b0;
    bus.abort    = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.busy && !busy_prev) begin
        req_k = 0;
        ack_at = -1;
        abort_at = -1;
      end
      if (bus.meas_req && !req_prev) begin
        d = (req_k < plan.size()) ? plan[req_k] : -1;
        if (d >= 0) ack_at = cyc + d;
        if (req_k == abort_k && d >= 0) begin
          abort_at  = cyc + d + 1 + abort_j;
          abort_cyc = abort_at;
        end
        req_k++;
      end
      bus.meas_ack = (cyc == ack_at);
      bus.abort    = (cyc == abort_at);
      req_prev  = bus.meas_req;
      busy_prev = bus.busy;
    end
  end

  // Monitor: compares every request and every done pulse against the queues.
  initial begin
    req_t  cur;
    done_t dn;
    logic  req_prev;
    int    req_len;
    req_prev = 0; req_len = 0; cur.len = -1;
    forever begin
      @(negedge clk);
      if (bus.meas_req && !req_prev) begin
        req_len = 0;
        check("req_expected", exp_req.size() > 0, 1);
        if (exp_req.size() > 0) begin
          cur = exp_req.pop_front();
          check("req_freq", bus.freq, cur.freq);
          check("req_port_sel", bus.port_sel, cur.port);
          check("req_point_idx", bus.point_idx, cur.idx);
          check("req_bias_en", bus.bias_en, 1);
          if (cur.cyc >= 0) check("first_req_latency", cyc, cur.cyc);
        end else begin
          cur.len = -1;
        end
      end
      if (bus.meas_req) req_len++;
      if (!bus.meas_req && req_prev && cur.len >= 0) check("req_high_len", req_len, cur.len);
      if (bus.done) begin
        check("done_expected", exp_done.size() > 0, 1);
        if (exp_done.size() > 0) begin
          dn = exp_done.pop_front();
          check("done_err_tmo", bus.err_tmo, dn.err);
          check("done_bias_en", bus.bias_en, 0);
          check("done_port_sel", bus.port_sel, 0);
          check("done_meas_req", bus.meas_req, 0);
          if (dn.cyc >= 0) check("done_cycle", cyc, dn.cyc);
          else if (dn.cyc == -2) check("abort_to_done", cyc, abort_cyc + 1);
        end
      end
      req_prev = bus.meas_req;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Stimulus: directed scenarios, then randomized sweeps, then reset mid-MEAS.
  initial begin
    int     n, mode, tk, ak, aj, sk;
    req_t   r;
    logic   got;
    bus.start = 0; bus.f_start = 0; bus.f_step = 0; bus.n_points = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    run_sweep(16'd100, 16'd25, 3, -1, -1, 0, 2, -1);         // nominal
    run_sweep(16'($urandom), 16'($urandom), 0, -1, -1, 0, -1, -1); // zero points
    run_sweep(16'd500, 16'd7, 3, 3, -1, 0, -1, -1);          // timeout at P1/port 2
    run_sweep(16'd1000, 16'd3, 3, -1, 2, 1, -1, -1);         // abort in SETTLE
    run_sweep(16'hFFF0, 16'h0010, 2, -1, -1, 0, -1, -1);     // frequency wrap
    run_sweep(16'd40, 16'd1, 2, -1, -1, 0, -1, 1);           // ack on timeout cycle

    repeat (12) begin
      n = $urandom_range(0, 4);
      mode = $urandom_range(0, 3);
      tk = -1; ak = -1; aj = 0; sk = -1;
      if (n > 0 && mode == 1) tk = $urandom_range(0, 2 * n - 1);
      if (n > 0 && mode == 2) begin
        ak = 2 * $urandom_range(0, n - 1);
        aj = $urandom_range(0, S - 1);
      end
      if (n > 0 && mode == 3) sk = $urandom_range(0, 2 * n - 1);
      run_sweep(16'($urandom), 16'($urandom), n, tk, ak, aj, -1, sk);
    end

    // Reset while a request is outstanding.
    plan.delete();
    plan.push_back(-1);
    abort_k = -1;
    r.freq = 16'd321; r.port = 2'b01; r.idx = 0; r.len = -1; r.cyc = cyc + 2 + B + S;
    exp_req.push_back(r);
    bus.f_start = 16'd321; bus.f_step = 16'd5; bus.n_points = 10'd4; bus.start = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.meas_req) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_reached_meas", got, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_req_drained", exp_req.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
